// File: rtl/clksw_pkg.sv
// clksw_pkg: shared state encoding and default sizing for the CPU clock-switch scheduler.
package clksw_pkg;
    typedef enum logic [1:0] {
        LS    = 2'd0,
        TO_HS = 2'd1,
        HS    = 2'd2,
        TO_LS = 2'd3
    } state_t;
    localparam int HOLDOFF_W_DEF = 3;
    localparam int TIMEOUT_DEF   = 15;
    localparam int CNT_W_DEF     = 8;
endpackage

// File: rtl/io_holdoff_ctr.sv
// io_holdoff_ctr: reloads on every IO-page access and counts down to zero; blocks HS selection while nonzero.
module io_holdoff_ctr
    import clksw_pkg::*;
#(
    parameter int W = HOLDOFF_W_DEF
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         active
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) cnt <= '0;
        else if (load) cnt <= len;
        else if (cnt != '0) cnt <= cnt - 1'b1;

    assign active = cnt != '0;
endmodule

// File: rtl/clksw_sched.sv
// clksw_sched: decides when the CPU may run on the high-speed clock and handshakes with the clock mux.
module clksw_sched
    import clksw_pkg::*;
#(
    parameter int HOLDOFF_W = HOLDOFF_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 hsclk_en,
    input  logic                 cyc_sync,
    input  logic                 cyc_himem,
    input  logic                 cyc_idle,
    input  logic                 cyc_io,
    input  logic [HOLDOFF_W-1:0] holdoff_len,
    input  logic                 hs_selected,
    input  logic                 ls_selected,
    input  logic                 err_clr,
    output logic                 hsclk_sel,
    output logic                 dummy_access,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     sw_cnt,
    output logic                 timeout_err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    state_t            st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              holdoff;
    logic              go_hs;
    logic              stay_hs;
    logic              expired;

    io_holdoff_ctr #(.W(HOLDOFF_W)) u_holdoff (
        .clk    (clk),
        .resetb (resetb),
        .load   (cyc_io),
        .len    (holdoff_len),
        .active (holdoff)
    );

    assign go_hs   = hsclk_en & cyc_sync & ~cyc_io & ~holdoff;
    assign stay_hs = hsclk_en & (cyc_himem | cyc_idle) & ~cyc_io;
    assign expired = wait_cnt == WAIT_W'(TIMEOUT - 1);

    // wait_cnt defaults to zero so every exit from a handshake state leaves it clear for the next entry
    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            st          <= LS;
            hsclk_sel   <= 1'b0;
            wait_cnt    <= '0;
            sw_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (err_clr) timeout_err <= 1'b0;
            wait_cnt <= '0;
            case (st)
                LS: if (go_hs) begin
                    st        <= TO_HS;
                    hsclk_sel <= 1'b1;
                end
                TO_HS: if (hs_selected) begin
                    st <= HS;
                    if (~&sw_cnt) sw_cnt <= sw_cnt + 1'b1;
                end else if (!hsclk_en) begin
                    st        <= TO_LS;
                    hsclk_sel <= 1'b0;
                end else if (expired) begin
                    st          <= LS;
                    hsclk_sel   <= 1'b0;
                    timeout_err <= 1'b1;
                end else wait_cnt <= wait_cnt + 1'b1;
                HS: if (!stay_hs) begin
                    st        <= TO_LS;
                    hsclk_sel <= 1'b0;
                end
                TO_LS: if (ls_selected) st <= LS;
                else if (expired) begin
                    st          <= LS;
                    timeout_err <= 1'b1;
                end else wait_cnt <= wait_cnt + 1'b1;
            endcase
        end

    assign state        = st;
    assign dummy_access = cyc_himem | (st != LS);
endmodule

// File: tb/tb_clksw_sched.sv
// tb_clksw_sched: directed scenarios plus randomized traffic checked every cycle against a behavioural model.
module tb_clksw_sched;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       hsclk_en, cyc_sync, cyc_himem, cyc_idle, cyc_io;
    logic [2:0] holdoff_len;
    logic       hs_selected, ls_selected, err_clr;
    logic       hsclk_sel, dummy_access, timeout_err;
    logic [1:0] state;
    logic [7:0] sw_cnt;

    int checks = 0;
    int failures = 0;

    int m_st, m_hold, m_wait, m_cnt, nxt;
    bit m_err, blk, ack;

    clksw_sched dut (
        .clk          (clk),
        .resetb       (resetb),
        .hsclk_en     (hsclk_en),
        .cyc_sync     (cyc_sync),
        .cyc_himem    (cyc_himem),
        .cyc_idle     (cyc_idle),
        .cyc_io       (cyc_io),
        .holdoff_len  (holdoff_len),
        .hs_selected  (hs_selected),
        .ls_selected  (ls_selected),
        .err_clr      (err_clr),
        .hsclk_sel    (hsclk_sel),
        .dummy_access (dummy_access),
        .state        (state),
        .sw_cnt       (sw_cnt),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: 0=low speed, 1=waiting for HS ack, 2=high speed, 3=waiting for LS ack
    always @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            m_st = 0; m_hold = 0; m_wait = 0; m_cnt = 0; m_err = 0;
        end else begin
            blk = m_hold > 0;
            nxt = m_st;
            if (err_clr) m_err = 0;
            if (m_st == 0) begin
                if (hsclk_en && cyc_sync && !cyc_io && !blk) nxt = 1;
            end else if (m_st == 2) begin
                if (!(hsclk_en && (cyc_himem || cyc_idle) && !cyc_io)) nxt = 3;
            end else begin
                ack = (m_st == 1) ? hs_selected : ls_selected;
                m_wait++;
                if (ack) begin
                    nxt = (m_st == 1) ? 2 : 0;
                    if (nxt == 2 && m_cnt < 255) m_cnt++;
                end else if (m_st == 1 && !hsclk_en) nxt = 3;
                else if (m_wait == TIMEOUT) begin
                    nxt = 0;
                    m_err = 1;
                end
            end
            if (nxt != m_st) m_wait = 0;
            m_hold = cyc_io ? int'(holdoff_len) : (m_hold > 0 ? m_hold - 1 : 0);
            m_st = nxt;
        end
    end

    always @(negedge clk)
        if (resetb) begin
            chk("state", 32'(state), 32'(m_st));
            chk("hsclk_sel", 32'(hsclk_sel), 32'(m_st == 1 || m_st == 2));
            chk("dummy_access", 32'(dummy_access), 32'(cyc_himem || m_st != 0));
            chk("sw_cnt", 32'(sw_cnt), 32'(m_cnt));
            chk("timeout_err", 32'(timeout_err), 32'(m_err));
        end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        hsclk_en = 0; cyc_sync = 0; cyc_himem = 0; cyc_idle = 0; cyc_io = 0;
        holdoff_len = 0; hs_selected = 0; ls_selected = 0; err_clr = 0;
    endtask

    task automatic do_reset();
        idle_in();
        resetb = 0;
        step();
        resetb = 1;
        step();
    endtask

    task automatic switch_cycle();
        hsclk_en = 1; cyc_sync = 1; hs_selected = 1; ls_selected = 0;
        step();
        step();
        hsclk_en = 0; cyc_sync = 0; hs_selected = 0; ls_selected = 1;
        step();
        step();
        ls_selected = 0;
    endtask

    initial begin
        int pct;
        idle_in();
        resetb = 0;
        step();
        step();
        chk("rst_state", 32'(state), 0);
        chk("rst_hsclk_sel", 32'(hsclk_sel), 0);
        chk("rst_sw_cnt", 32'(sw_cnt), 0);
        chk("rst_err", 32'(timeout_err), 0);
        chk("rst_dummy", 32'(dummy_access), 0);
        resetb = 1;
        step();
        chk("post_rst_state", 32'(state), 0);

        hsclk_en = 1; cyc_sync = 1;
        step();
        chk("to_hs_state", 32'(state), 1);
        chk("to_hs_sel", 32'(hsclk_sel), 1);
        cyc_sync = 0;
        step();
        chk("to_hs_wait", 32'(state), 1);
        hs_selected = 1;
        step();
        chk("hs_state", 32'(state), 2);
        chk("hs_sw_cnt", 32'(sw_cnt), 1);

        hs_selected = 0; cyc_io = 1; holdoff_len = 3;
        step();
        chk("io_exit_hs", 32'(state), 3);
        chk("io_exit_sel", 32'(hsclk_sel), 0);
        cyc_io = 0; ls_selected = 1; cyc_sync = 1;
        step();
        chk("ls_ack", 32'(state), 0);
        ls_selected = 0;
        step();
        chk("holdoff_blk1", 32'(state), 0);
        step();
        chk("holdoff_blk2", 32'(state), 0);
        step();
        chk("holdoff_done", 32'(state), 1);
        cyc_sync = 0; hs_selected = 1;
        step();
        chk("hs_again_cnt", 32'(sw_cnt), 2);

        hs_selected = 0; hsclk_en = 0;
        step();
        ls_selected = 1;
        step();
        chk("back_ls", 32'(state), 0);
        ls_selected = 0; hsclk_en = 1; cyc_sync = 1;
        step();
        cyc_sync = 0;
        repeat (TIMEOUT - 1) step();
        chk("tmo_pending", 32'(state), 1);
        step();
        chk("tmo_state", 32'(state), 0);
        chk("tmo_sel", 32'(hsclk_sel), 0);
        chk("tmo_err", 32'(timeout_err), 1);
        err_clr = 1;
        step();
        chk("err_clr", 32'(timeout_err), 0);
        err_clr = 0;

        holdoff_len = 0; cyc_sync = 1; cyc_io = 1;
        step();
        chk("io_sync_block", 32'(state), 0);
        cyc_io = 0;
        step();
        chk("io_sync_next", 32'(state), 1);
        hsclk_en = 0; cyc_sync = 0;
        step();
        chk("abort", 32'(state), 3);
        ls_selected = 1;
        step();
        ls_selected = 0;

        do_reset();
        repeat (5) switch_cycle();
        hsclk_en = 1; cyc_sync = 1;
        step();
        chk("pre_rst_state", 32'(state), 1);
        chk("pre_rst_cnt", 32'(sw_cnt), 5);
        #1 resetb = 0;
        #1;
        chk("async_state", 32'(state), 0);
        chk("async_sel", 32'(hsclk_sel), 0);
        chk("async_cnt", 32'(sw_cnt), 0);
        chk("async_err", 32'(timeout_err), 0);
        chk("async_dummy", 32'(dummy_access), 0);
        idle_in();
        step();
        resetb = 1;
        step();

        pct = 30;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) pct = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 10 : 50);
            hsclk_en    = $urandom_range(0, 9) != 0;
            cyc_sync    = $urandom_range(0, 1);
            cyc_himem   = $urandom_range(0, 3) != 0;
            cyc_idle    = $urandom_range(0, 3) == 0;
            cyc_io      = $urandom_range(0, 9) == 0;
            holdoff_len = 3'($urandom_range(0, 7));
            hs_selected = $urandom_range(0, 99) < pct;
            ls_selected = $urandom_range(0, 99) < pct;
            err_clr     = $urandom_range(0, 19) == 0;
            step();
        end

        do_reset();
        repeat (300) switch_cycle();
        chk("sat_cnt", 32'(sw_cnt), 255);
        chk("sat_state", 32'(state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clksw_sched.md
CLKSW_SCHED -- requirements
Module: clksw_sched

Interface
REQ-001 SHALL have parameter HOLDOFF_W, default 3, width of IO holdoff length/counter.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles waiting for clock-switch acknowledge.
REQ-003 SHALL have parameter CNT_W, default 8, width of completed-switch counter.
REQ-004 SHALL have port clk  in  1  CPU clock; all state updates on rising edge (end of CPU cycle).
REQ-005 SHALL have port resetb  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port hsclk_en  in  1  high-speed clock enable from mapping register.
REQ-007 SHALL have port cyc_sync  in  1  current cycle is an instruction fetch from himem.
REQ-008 SHALL have port cyc_himem  in  1  current cycle is a valid himem access, excluding himem video-RAM writes.
REQ-009 SHALL have port cyc_idle  in  1  current cycle has neither VPA nor VDA.
REQ-010 SHALL have port cyc_io  in  1  current cycle is a valid lomem IO-page access (FC00-FFFF).
REQ-011 SHALL have port holdoff_len  in  HOLDOFF_W  cycles to block HS selection after an IO access.
REQ-012 SHALL have port hs_selected  in  1  clock mux acknowledge: HS clock driving CPU.
REQ-013 SHALL have port ls_selected  in  1  clock mux acknowledge: BBC clock driving CPU.
REQ-014 SHALL have port err_clr  in  1  clears timeout_err.
REQ-015 SHALL have port hsclk_sel  out  1  registered request to clock mux for HS clock.
REQ-016 SHALL have port dummy_access  out  1  force BBC bus dummy read this cycle.
REQ-017 SHALL have port state  out  2  current FSM state.
REQ-018 SHALL have port sw_cnt  out  CNT_W  count of completed LS->HS switches.
REQ-019 SHALL have port timeout_err  out  1  sticky handshake-timeout flag.

Function
REQ-020 FSM states SHALL be LS=0, TO_HS=1, HS=2, TO_LS=3; hsclk_sel SHALL be 1 exactly in TO_HS and HS.
REQ-021 Holdoff counter SHALL load holdoff_len on any edge with cyc_io=1, else decrement, saturating at 0; holdoff is active while the counter is nonzero.
REQ-022 LS->TO_HS SHALL occur when hsclk_en & cyc_sync & !cyc_io & holdoff inactive.
REQ-023 TO_HS->HS SHALL occur on an edge sampling hs_selected=1; with hsclk_en=0 and no ack, it SHALL go TO_LS (abort).
REQ-024 HS SHALL be held while hsclk_en & (cyc_himem | cyc_idle) & !cyc_io; otherwise HS->TO_LS.
REQ-025 TO_LS->LS SHALL occur on an edge sampling ls_selected=1.
REQ-026 A wait counter SHALL clear on entry to TO_HS/TO_LS and increment each cycle there; at TIMEOUT with no ack, the FSM SHALL go to LS and set timeout_err.
REQ-027 sw_cnt SHALL increment on each TO_HS->HS transition and saturate at all-ones.
REQ-028 err_clr SHALL clear timeout_err; a simultaneous set SHALL take priority.
REQ-029 dummy_access SHALL be combinational: cyc_himem | (state != LS).
REQ-030 cyc_io and cyc_sync in the same cycle SHALL load holdoff and SHALL NOT start a switch.
REQ-031 With holdoff_len=0, cyc_io SHALL block only its own cycle.
REQ-032 Ack inputs SHALL be ignored in LS and HS.

Reset
REQ-033 On resetb=0, at any time including mid-handshake: state=LS, hsclk_sel=0, holdoff=0, wait counter=0, sw_cnt=0, timeout_err=0.
REQ-034 No output SHALL glitch high after reset release until a qualifying transition occurs.

Structure
REQ-035 State encoding and default HOLDOFF_W/TIMEOUT/CNT_W values SHALL live in a shared package, clksw_pkg.
REQ-036 The holdoff counter SHALL be one sub-module, io_holdoff_ctr; the FSM, wait counter and sw_cnt stay in clksw_sched.

Verification
REQ-037 Stimulus: hsclk_en=1, cyc_sync=1, hs_selected set 2 cycles later. Required: state 0->1->2, hsclk_sel=1 from edge 1, sw_cnt=1.
REQ-038 Stimulus: in HS, cyc_io=1 with holdoff_len=3, ls_selected after 1 cycle, then cyc_sync each cycle. Required: state 2->3->0; no TO_HS until 3 cycles after the IO access.
REQ-039 Stimulus: in TO_HS, hs_selected held 0 for 15 cycles. Required: state=0, hsclk_sel=0, timeout_err=1; err_clr=1 then clears it.
REQ-040 Stimulus: cyc_sync=1 and cyc_io=1 together, holdoff_len=0. Required: no switch that cycle; switch on the next cyc_sync.
REQ-041 Stimulus: resetb pulsed low in TO_HS after sw_cnt=5. Required: all outputs reset immediately, sw_cnt=0.
REQ-042 Stimulus: 300 complete switch cycles with CNT_W=8. Required: sw_cnt holds at 255.
